// File: rtl/video_mux_pkg.sv
// Shared types for the video mux controller.
//   bg_mode_t     : background source select driven onto bg_out
//   target_mode_t : overlay select driven onto target_out
//   ctrl_state_t  : controller FSM states
// Helper functions compute the next pending mode on a button press.
package video_mux_pkg;

  typedef enum logic [1:0] {
    CAM    = 2'b00,
    CHAN   = 2'b01,
    THRESH = 2'b10,
    YMASK  = 2'b11
  } bg_mode_t;

  typedef enum logic [1:0] {
    NONE   = 2'b00,
    XHAIR  = 2'b01,
    SPRITE = 2'b10,
    TEST   = 2'b11
  } target_mode_t;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } ctrl_state_t;

  function automatic bg_mode_t bg_next(input bg_mode_t m);
    return bg_mode_t'(m + 2'd1);
  endfunction

  // skip_test removes the test-color overlay from the cycle (used in AUTO).
  function automatic target_mode_t tgt_next(input target_mode_t m, input logic skip_test);
    if (skip_test && (m == SPRITE)) begin
      return NONE;
    end
    return target_mode_t'(m + 2'd1);
  endfunction

endpackage

// File: rtl/debouncer.sv
// Button conditioner: 2-FF synchronizer followed by a level debouncer.
// clean_out only follows the synchronized input after DEBOUNCE_CYCLES
// consecutive samples that differ from the current clean level.
//   clk_pixel_in : clock
//   rst_in       : synchronous active-high reset
//   dirty_in     : raw asynchronous button level
//   clean_out    : debounced level
module debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic clk_pixel_in,
  input  logic rst_in,
  input  logic dirty_in,
  output logic clean_out
);

  localparam int unsigned CntW = ($clog2(DEBOUNCE_CYCLES + 1) > 0) ?
                                 $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            clean_q, clean_d;

  // cnt_q counts consecutive samples that disagree with clean_q; it is
  // cleared on agreement or on acceptance, so it never passes CntLast.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    if (sync_q[1] == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CntLast) begin
      clean_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], dirty_in};
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign clean_out = clean_q;

endmodule

// File: rtl/video_mux_ctrl.sv
// Video mux mode controller. Button presses and the auto-advance timer
// update pending modes; the active selects load from the pending modes
// only at new_frame_in so a mode never changes mid-frame.
//   clk_pixel_in    : pixel clock
//   rst_in          : synchronous active-high reset
//   btn_bg_in       : raw button, advances background mode
//   btn_target_in   : raw button, advances overlay mode
//   auto_en_in      : 1 = AUTO, 0 = MANUAL
//   new_frame_in    : one-cycle pulse at start of vertical blanking
//   bg_out          : active background select
//   target_out      : active overlay select
//   mode_change_out : one-cycle pulse when either select changes
module video_mux_ctrl
  import video_mux_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned AUTO_FRAMES     = 120
) (
  input  logic       clk_pixel_in,
  input  logic       rst_in,
  input  logic       btn_bg_in,
  input  logic       btn_target_in,
  input  logic       auto_en_in,
  input  logic       new_frame_in,
  output logic [1:0] bg_out,
  output logic [1:0] target_out,
  output logic       mode_change_out
);

  localparam int unsigned FcW = ($clog2(AUTO_FRAMES) > 0) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [FcW-1:0] FcLast = FcW'(AUTO_FRAMES - 1);

  logic bg_clean, tgt_clean;
  logic bg_clean_q, tgt_clean_q;
  logic bg_press, tgt_press;

  ctrl_state_t  state_q, state_d;
  logic [FcW-1:0] frame_cnt_q, frame_cnt_d;
  bg_mode_t     bg_pend_q, bg_pend_d, bg_q, bg_d;
  target_mode_t tgt_pend_q, tgt_pend_d, tgt_q, tgt_d;
  logic         mc_q, mc_d;

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_bg (
    .clk_pixel_in(clk_pixel_in),
    .rst_in      (rst_in),
    .dirty_in    (btn_bg_in),
    .clean_out   (bg_clean)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_tgt (
    .clk_pixel_in(clk_pixel_in),
    .rst_in      (rst_in),
    .dirty_in    (btn_target_in),
    .clean_out   (tgt_clean)
  );

  // Rising edge of the debounced level only; release gives no pulse.
  assign bg_press  = bg_clean & ~bg_clean_q;
  assign tgt_press = tgt_clean & ~tgt_clean_q;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    bg_pend_d   = bg_pend_q;
    tgt_pend_d  = tgt_pend_q;
    bg_d        = bg_q;
    tgt_d       = tgt_q;
    mc_d        = 1'b0;

    // Commit uses the registered pending values, so a press or auto advance
    // in this same cycle lands at the following frame.
    if (new_frame_in) begin
      bg_d  = bg_pend_q;
      tgt_d = tgt_pend_q;
      mc_d  = (bg_pend_q != bg_q) || (tgt_pend_q != tgt_q);
    end

    case (state_q)
      MANUAL: begin
        if (bg_press)  bg_pend_d  = bg_next(bg_pend_q);
        if (tgt_press) tgt_pend_d = tgt_next(tgt_pend_q, 1'b0);
        if (auto_en_in) begin
          state_d     = AUTO;
          frame_cnt_d = '0;
          // Test color is not part of the AUTO overlay cycle.
          if (tgt_pend_d == TEST) tgt_pend_d = NONE;
        end
      end
      AUTO: begin
        if (tgt_press) tgt_pend_d = tgt_next(tgt_pend_q, 1'b1);
        if (new_frame_in) begin
          if (frame_cnt_q >= FcLast) begin
            frame_cnt_d = '0;
            bg_pend_d   = bg_next(bg_pend_q);
          end else begin
            frame_cnt_d = frame_cnt_q + FcW'(1);
          end
        end
        if (!auto_en_in) state_d = MANUAL;
      end
      default: state_d = MANUAL;
    endcase
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      bg_clean_q  <= 1'b0;
      tgt_clean_q <= 1'b0;
      state_q     <= MANUAL;
      frame_cnt_q <= '0;
      bg_pend_q   <= CAM;
      tgt_pend_q  <= NONE;
      bg_q        <= CAM;
      tgt_q       <= NONE;
      mc_q        <= 1'b0;
    end else begin
      bg_clean_q  <= bg_clean;
      tgt_clean_q <= tgt_clean;
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      bg_pend_q   <= bg_pend_d;
      tgt_pend_q  <= tgt_pend_d;
      bg_q        <= bg_d;
      tgt_q       <= tgt_d;
      mc_q        <= mc_d;
    end
  end

  assign bg_out          = bg_q;
  assign target_out      = tgt_q;
  assign mode_change_out = mc_q;

endmodule

// File: doc/video_mux_ctrl.md
VIDEO_MUX_CTRL -- requirements
Module: video_mux_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 2_000_000, number of consecutive stable samples required to accept a button level.
REQ-002 Parameter AUTO_FRAMES, default 120, number of frames between automatic background-mode advances.
REQ-003 clk_pixel_in  input  1  pixel clock; the only clock.
REQ-004 rst_in  input  1  reset, synchronous and active-high.
REQ-005 btn_bg_in  input  1  raw, asynchronous button; each press advances the background mode.
REQ-006 btn_target_in  input  1  raw, asynchronous button; each press advances the overlay mode.
REQ-007 auto_en_in  input  1  level; 1 selects AUTO state, 0 selects MANUAL state.
REQ-008 new_frame_in  input  1  single-cycle pulse at the start of the vertical blanking interval.
REQ-009 bg_out  output  2  active background select: 00 camera, 01 channel gray, 10 threshold, 11 Y plus mask.
REQ-010 target_out  output  2  active overlay select: 00 none, 01 crosshair, 10 sprite, 11 test color.
REQ-011 mode_change_out  output  1  single-cycle pulse when bg_out or target_out changes value.

Function
REQ-012 Each button SHALL pass through a 2-FF synchronizer, then a debouncer that updates its output level only after DEBOUNCE_CYCLES consecutive identical samples.
REQ-013 A 0->1 transition of a debounced level SHALL produce exactly one press pulse, one cycle wide; releasing the button SHALL produce no pulse.
REQ-014 The block SHALL hold pending registers bg_pend and tgt_pend, which are separate from the active outputs.
REQ-015 A bg press SHALL set bg_pend to bg_pend+1 mod 4 (11 wraps to 00); a target press SHALL set tgt_pend to tgt_pend+1 mod 4.
REQ-016 Outputs SHALL change only in the cycle after new_frame_in=1, when bg_out<=bg_pend and target_out<=tgt_pend; this avoids mid-frame tearing.
REQ-017 mode_change_out SHALL be 1 in that same cycle only if at least one output value changed, and 0 otherwise.
REQ-018 If a press and new_frame_in occur in the same cycle, the commit SHALL use the pre-press pending value, and the press SHALL appear at the next frame.
REQ-019 The FSM SHALL have two states: MANUAL and AUTO.
REQ-020 MANUAL SHALL go to AUTO when auto_en_in=1, and AUTO SHALL go to MANUAL when auto_en_in=0; each transition takes one cycle.
REQ-021 On entry to AUTO, frame_cnt SHALL clear to 0.
REQ-022 In AUTO, each new_frame_in SHALL increment frame_cnt.
REQ-023 When frame_cnt reaches AUTO_FRAMES-1 and new_frame_in=1, frame_cnt SHALL become 0 and bg_pend SHALL advance mod 4.
REQ-024 The advance in REQ-023 SHALL be committed at the following frame, consistent with REQ-018.
REQ-025 In AUTO, bg presses SHALL be ignored.
REQ-026 In AUTO, target presses SHALL still act, but SHALL skip 11: 10 wraps to 00.
REQ-027 If tgt_pend=11 when AUTO is entered, tgt_pend SHALL be forced to 00.
REQ-028 Returning to MANUAL SHALL keep the current pending and active values.
REQ-029 frame_cnt SHALL be at least clog2(AUTO_FRAMES) bits wide.
REQ-030 The debounce counter SHALL be at least clog2(DEBOUNCE_CYCLES+1) bits wide and SHALL saturate, never wrapping.
REQ-031 new_frame_in SHALL be treated as already synchronous to clk_pixel_in; it is not synchronized inside the block.

Reset
REQ-032 While rst_in=1 at a clock edge, the block SHALL set: bg_out=00, target_out=00, bg_pend=00, tgt_pend=00, mode_change_out=0, frame_cnt=0, state=MANUAL.
REQ-033 While rst_in=1, the debounced levels SHALL be 0, the debounce counters 0 and the synchronizers 0.
REQ-034 A reset asserted mid-debounce or mid-AUTO SHALL abort the operation in progress with no press pulse and no mode_change_out pulse.
REQ-035 In the first cycle after reset deasserts, a button already held high SHALL still need DEBOUNCE_CYCLES stable samples before producing a press.

Structure
REQ-036 Package video_mux_pkg SHALL define the following shared by the mux and the controller: enum bg_mode_t (CAM, CHAN, THRESH, YMASK), enum target_mode_t (NONE, XHAIR, SPRITE, TEST) and enum ctrl_state_t (MANUAL, AUTO).
REQ-037 The debounce function SHALL be a sub-module named debouncer, instantiated twice.
REQ-038 debouncer ports SHALL be: clk_pixel_in, rst_in, dirty_in, clean_out; parameter DEBOUNCE_CYCLES.
REQ-039 All state SHALL be clocked on clk_pixel_in only, and the module SHALL contain no latches.

Verification (DEBOUNCE_CYCLES=4, AUTO_FRAMES=3)
REQ-040 Scenario 1: hold btn_bg_in high for 10 cycles, then pulse new_frame_in -> one cycle after new_frame_in, bg_out=01 and mode_change_out=1 for exactly one cycle.
REQ-041 Scenario 2: btn_bg_in glitches high for 2 cycles -> bg_pend unchanged and no output change at the next frame.
REQ-042 Scenario 3: make 4 separate bg presses, then one frame -> bg_out=00 (wrap) and mode_change_out=0.
REQ-043 Scenario 4: press target debounced so its pulse coincides with new_frame_in -> target_out unchanged at that frame and target_out=01 at the next frame.
REQ-044 Scenario 5: auto_en_in=1 from reset, apply 7 frames -> bg_out=00 through frame 3, 01 at frame 4, 10 at frame 7; bg presses have no effect.
REQ-045 Scenario 6: with tgt_pend=11, set auto_en_in=1 -> target_out=00 at the next frame; assert rst_in mid-press -> all outputs 00 and no pulses.
